pcie_mwr_initiator: RTL and testbench



---
 rtl/pcie_tlp_pkg.sv | 25 ++
 rtl/pcie_mwr_initiator_if.sv | 19 +
 rtl/pcie_dwfifo.sv | 46 ++++
 rtl/pcie_mwr_initiator.sv | 180 ++++++++++++++++++
 tb/tb_pcie_mwr_initiator.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_tlp_pkg.sv
// Shared TLP encodings, TRN remainder codes and the initiator state type.
package pcie_tlp_pkg;

  localparam logic [6:0] FMT_TYPE_MWR32 = 7'b10_00000;
  localparam logic [6:0] FMT_TYPE_CPLD  = 7'b10_01010;

  localparam logic [7:0] TRN_REM_BOTH  = 8'h00;
  localparam logic [7:0] TRN_REM_UPPER = 8'h0F;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StWaitData,
    StHdr,
    StAddr,
    StData,
    StNext
  } mwr_state_e;

  // Host memory is little-endian; TRN carries DW bytes in wire order.
  function automatic logic [31:0] swap_dwb(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/pcie_mwr_initiator_if.sv
// TRN TX local-link between the MWr initiator and the endpoint core.
interface pcie_mwr_initiator_if;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;

  modport master (
    output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  trn_tdst_rdy_n
  );

  modport slave (
    input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output trn_tdst_rdy_n
  );
endinterface

// File: rtl/pcie_dwfifo.sv
// DWORD FIFO: single-DW push, 0/1/2-DW pop, two-entry peek, async-reset flush.
module pcie_dwfifo #(
  parameter int unsigned AddrWidth = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [31:0]          wr_data_i,
  input  logic [1:0]           pop_i,
  output logic                 full_o,
  output logic [AddrWidth:0]   cnt_o,
  output logic [31:0]          rd_data0_o,
  output logic [31:0]          rd_data1_o
);
  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [31:0]          mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   cnt_q;
  logic                 push;

  assign full_o = (cnt_q == (AddrWidth + 1)'(Depth));
  assign push   = wr_en_i & ~full_o;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
      rd_ptr_q <= rd_ptr_q + AddrWidth'(pop_i);
      cnt_q    <= cnt_q + (AddrWidth + 1)'(push) - (AddrWidth + 1)'(pop_i);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data0_o = mem_q[rd_ptr_q];
  assign rd_data1_o = mem_q[rd_ptr_q + AddrWidth'(1)];

endmodule

// File: rtl/pcie_mwr_initiator.sv
// Bus-master MWr32 TLP generator on the 64-bit TRN TX link.
// Optional MSI-on-done request enabled by defining MWR_DONE_IRQ_EN.
module pcie_mwr_initiator
  import pcie_tlp_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD_DW = 32,
  parameter int unsigned FIFO_AW        = 6
) (
  input  logic                clk,
  input  logic                sys_reset_n,
  input  logic                start,
  input  logic [29:0]         cmd_addr,
  input  logic [15:0]         cmd_len_dw,
  output logic                busy,
  output logic                done,
  input  logic                wr_en,
  input  logic [31:0]         wr_data,
  output logic                fifo_full,
  output logic [FIFO_AW:0]    fifo_cnt,
  input  logic [7:0]          cfg_bus_number,
  input  logic [4:0]          cfg_device_number,
  input  logic [2:0]          cfg_function_number,
  pcie_mwr_initiator_if.master trn
`ifdef MWR_DONE_IRQ_EN
  ,
  output logic                cfg_interrupt_n,
  input  logic                cfg_interrupt_rdy_n
`endif
);
  mwr_state_e  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic [10:0] len_q, len_d;
  logic [10:0] dw_left_q, dw_left_d;

  logic [1:0]  pop;
  logic [31:0] rd_data0, rd_data1;
  logic [10:0] to_bound, cap;
  logic [31:0] hdr_dw0, hdr_dw1;
  logic [63:0] td;
  logic [7:0]  trem_n;
  logic        sof_n, eof_n, src_rdy_n, accept, done_c;

  pcie_dwfifo #(
    .AddrWidth(FIFO_AW)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (sys_reset_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .cnt_o     (fifo_cnt),
    .rd_data0_o(rd_data0),
    .rd_data1_o(rd_data1)
  );

  assign accept   = ~src_rdy_n & ~trn.trn_tdst_rdy_n;
  assign to_bound = 11'd1024 - {1'b0, addr_q[9:0]};
  assign hdr_dw0  = {1'b0, FMT_TYPE_MWR32, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
                     len_q[9:0]};
  assign hdr_dw1  = {cfg_bus_number, cfg_device_number, cfg_function_number, 8'h00,
                     (len_q == 11'd1) ? 4'h0 : 4'hF, 4'hF};

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      remain_q  <= '0;
      len_q     <= '0;
      dw_left_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      len_q     <= len_d;
      dw_left_q <= dw_left_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    len_d     = len_q;
    dw_left_d = dw_left_q;
    pop       = 2'd0;
    done_c    = 1'b0;
    td        = '0;
    trem_n    = TRN_REM_BOTH;
    sof_n     = 1'b1;
    eof_n     = 1'b1;
    src_rdy_n = 1'b1;
    cap       = (remain_q > 16'(MAX_PAYLOAD_DW)) ? 11'(MAX_PAYLOAD_DW) : remain_q[10:0];
    if (cap > to_bound) cap = to_bound;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len_dw;
          len_d    = '0;
          // Zero-length commands fall straight through to the done pulse.
          state_d  = (cmd_len_dw == 16'd0) ? StNext : StCalc;
        end
      end
      StCalc: begin
        len_d   = cap;
        state_d = StWaitData;
      end
      StWaitData: begin
        if (32'(fifo_cnt) >= 32'(len_q)) state_d = StHdr;
      end
      StHdr: begin
        src_rdy_n = 1'b0;
        sof_n     = 1'b0;
        td        = {hdr_dw0, hdr_dw1};
        if (accept) state_d = StAddr;
      end
      StAddr: begin
        src_rdy_n = 1'b0;
        td        = {addr_q, 2'b00, swap_dwb(rd_data0)};
        eof_n     = (len_q != 11'd1);
        if (accept) begin
          pop       = 2'd1;
          dw_left_d = len_q - 11'd1;
          state_d   = (len_q == 11'd1) ? StNext : StData;
        end
      end
      StData: begin
        src_rdy_n = 1'b0;
        eof_n     = (dw_left_q > 11'd2);
        if (dw_left_q >= 11'd2) begin
          td = {swap_dwb(rd_data0), swap_dwb(rd_data1)};
        end else begin
          td     = {swap_dwb(rd_data0), 32'h0};
          trem_n = TRN_REM_UPPER;
        end
        if (accept) begin
          pop       = (dw_left_q >= 11'd2) ? 2'd2 : 2'd1;
          dw_left_d = dw_left_q - 11'(pop);
          if (!eof_n) state_d = StNext;
        end
      end
      StNext: begin
        addr_d   = addr_q + {19'd0, len_q};
        remain_d = remain_q - {5'd0, len_q};
        if (remain_q == {5'd0, len_q}) begin
          done_c  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StCalc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy               = (state_q != StIdle);
  assign done               = done_c;
  assign trn.trn_td         = td;
  assign trn.trn_trem_n     = trem_n;
  assign trn.trn_tsof_n     = sof_n;
  assign trn.trn_teof_n     = eof_n;
  assign trn.trn_tsrc_rdy_n = src_rdy_n;

`ifdef MWR_DONE_IRQ_EN
  logic irq_q;

  // A done while already pending just keeps the single request outstanding.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n)              irq_q <= 1'b0;
    else if (done_c)               irq_q <= 1'b1;
    else if (!cfg_interrupt_rdy_n) irq_q <= 1'b0;
  end

  assign cfg_interrupt_n = ~irq_q;
`endif

endmodule

// File: tb/tb_pcie_mwr_initiator.sv
// Scoreboard bench for pcie_mwr_initiator: expected beats queued at command issue.
module tb_pcie_mwr_initiator;
  import pcie_tlp_pkg::*;

  localparam int unsigned MaxPayloadDw = 32;
  localparam int unsigned FifoAw       = 6;

  logic             clk = 1'b0;
  logic             sys_reset_n = 1'b0;
  logic             start = 1'b0;
  logic [29:0]      cmd_addr = '0;
  logic [15:0]      cmd_len_dw = '0;
  logic             busy, done, fifo_full;
  logic             wr_en = 1'b0;
  logic [31:0]      wr_data = '0;
  logic [FifoAw:0]  fifo_cnt;
  logic [7:0]       bus = 8'h3C;
  logic [4:0]       dev = 5'h0A;
  logic [2:0]       fn  = 3'h5;
`ifdef MWR_DONE_IRQ_EN
  logic             irq_n;
`endif

  always #5 clk = ~clk;

  pcie_mwr_initiator_if trn ();

  pcie_mwr_initiator #(
    .MAX_PAYLOAD_DW(MaxPayloadDw),
    .FIFO_AW       (FifoAw)
  ) dut (
    .clk                (clk),
    .sys_reset_n        (sys_reset_n),
    .start              (start),
    .cmd_addr           (cmd_addr),
    .cmd_len_dw         (cmd_len_dw),
    .busy               (busy),
    .done               (done),
    .wr_en              (wr_en),
    .wr_data            (wr_data),
    .fifo_full          (fifo_full),
    .fifo_cnt           (fifo_cnt),
    .cfg_bus_number     (bus),
    .cfg_device_number  (dev),
    .cfg_function_number(fn),
    .trn                (trn)
`ifdef MWR_DONE_IRQ_EN
    ,
    .cfg_interrupt_n    (irq_n),
    .cfg_interrupt_rdy_n(1'b0)
`endif
  );

  typedef struct packed {
    logic [63:0] td;
    logic [7:0]  trem;
    logic        sof_n;
    logic        eof_n;
    logic [10:0] len;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] pay_q[$];
  int          obs_len[$];
  logic [31:0] obs_addr[$];

  int n_chk = 0;
  int n_pass = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int push_gap = 0;
  bit push_on = 1'b1;
  bit stall_en = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Reference split: min(remaining, max payload, DWs to 4 KB boundary).
  task automatic expect_cmd(input logic [31:0] baddr, input int len);
    logic [29:0] a;
    int rem, l, k;
    beat_t b;
    logic [31:0] d0, d1;
    a = baddr[31:2];
    rem = len;
    while (rem > 0) begin
      l = rem;
      if (l > int'(MaxPayloadDw)) l = MaxPayloadDw;
      if (l > 1024 - int'(a[9:0])) l = 1024 - int'(a[9:0]);
      b.td    = {32'h4000_0000 | 32'(l % 1024), bus, dev, fn, 8'h00,
                 (l == 1) ? 4'h0 : 4'hF, 4'hF};
      b.trem  = 8'h00;
      b.sof_n = 1'b0;
      b.eof_n = 1'b1;
      b.len   = 11'(l);
      exp_q.push_back(b);
      d0      = pay_q.pop_front();
      b.td    = {a, 2'b00, bswap(d0)};
      b.sof_n = 1'b1;
      b.eof_n = (l == 1) ? 1'b0 : 1'b1;
      exp_q.push_back(b);
      k = 1;
      while (k < l) begin
        d0 = pay_q.pop_front();
        if (l - k >= 2) begin
          d1     = pay_q.pop_front();
          b.td   = {bswap(d0), bswap(d1)};
          b.trem = 8'h00;
          k += 2;
        end else begin
          b.td   = {bswap(d0), 32'h0};
          b.trem = 8'h0F;
          k += 1;
        end
        b.eof_n = (k >= l) ? 1'b0 : 1'b1;
        exp_q.push_back(b);
      end
      a   = a + 30'(l);
      rem = rem - l;
    end
  endtask

  // Data source: pushes the designated stream whenever the FIFO has room.
  int gc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (sys_reset_n && push_on && src_q.size() > 0 && !fifo_full) begin
        if (gc == 0) begin
          wr_en   = 1'b1;
          wr_data = src_q.pop_front();
          gc      = push_gap;
        end else begin
          gc--;
        end
      end
    end
  end

  initial begin
    trn.trn_tdst_rdy_n = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      trn.trn_tdst_rdy_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  logic [82:0] cur, snap_prev;
  logic [63:0] mask;
  beat_t       e;
  bit          stall_prev = 1'b0;
  bit          in_pkt = 1'b0;
  bit          want_addr = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!sys_reset_n) begin
      stall_prev = 1'b0;
      in_pkt     = 1'b0;
      want_addr  = 1'b0;
    end else begin
      cur = {trn.trn_td, trn.trn_trem_n, trn.trn_tsof_n, trn.trn_teof_n, trn.trn_tsrc_rdy_n,
             1'b0};
      if (stall_prev) check("stall_hold", cur, snap_prev);
      if (in_pkt) check("rdy_gap", trn.trn_tsrc_rdy_n, 1'b0);
      stall_prev = !trn.trn_tsrc_rdy_n && trn.trn_tdst_rdy_n;
      snap_prev  = cur;
      if (!trn.trn_tsrc_rdy_n && !trn.trn_tdst_rdy_n) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          e    = exp_q.pop_front();
          mask = (e.trem == 8'h0F) ? 64'hFFFF_FFFF_0000_0000 : '1;
          check("beat", {trn.trn_td & mask, trn.trn_trem_n, trn.trn_tsof_n, trn.trn_teof_n},
                {e.td & mask, e.trem, e.sof_n, e.eof_n});
          if (!trn.trn_tsof_n) check("sof_fifo", 32'(fifo_cnt) >= 32'(e.len), 1'b1);
        end
        if (want_addr) begin
          obs_addr.push_back(trn.trn_td[63:32]);
          want_addr = 1'b0;
        end
        if (!trn.trn_tsof_n) begin
          obs_len.push_back(int'(trn.trn_td[41:32]));
          want_addr = 1'b1;
          in_pkt    = 1'b1;
        end
        if (!trn.trn_teof_n) in_pkt = 1'b0;
      end
    end
  end

  task automatic queue_data(input int n, input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 32'(i) * step);
      pay_q.push_back(base + 32'(i) * step);
    end
  endtask

  task automatic clear_obs();
    done_cnt   = 0;
    beats_seen = 0;
    obs_len.delete();
    obs_addr.delete();
  endtask

  task automatic run_cmd(input logic [31:0] baddr, input int len);
    expect_cmd(baddr, len);
    @(posedge clk);
    #1;
    start      = 1'b1;
    cmd_addr   = baddr[31:2];
    cmd_len_dw = 16'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("timeout", c < budget, 1'b1);
    check("exp_left", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_trn"}, {trn.trn_tsrc_rdy_n, trn.trn_tsof_n, trn.trn_teof_n, trn.trn_trem_n},
          {3'b111, 8'h00});
    check({tag, "_td"}, trn.trn_td, 64'h0);
    check({tag, "_cnt"}, fifo_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c;
    #2;
    check_idle_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    sys_reset_n = 1'b1;

    // Prefilled single 4-DW TLP.
    clear_obs();
    queue_data(4, 32'h1122_3344, 32'h1111_1111);
    repeat (6) @(posedge clk);
    #1;
    check("prefill_cnt", fifo_cnt, 4);
    run_cmd(32'h1000_0000, 4);
    wait_done(200);
    check("t1_beats", beats_seen, 4);
    check("t1_done", done_cnt, 1);
    check("t1_dw0", obs_len.size() == 1 && obs_len[0] == 4, 1'b1);
    check("t1_addr", obs_addr.size() == 1 && obs_addr[0] == 32'h1000_0000, 1'b1);

    // Single-DW TLP: eof on the address beat.
    clear_obs();
    queue_data(1, 32'hDEAD_BEEF, 32'h0);
    run_cmd(32'h2000_0010, 1);
    wait_done(200);
    check("t2_beats", beats_seen, 2);
    check("t2_done", done_cnt, 1);

    // Zero-length command: done without any TLP.
    clear_obs();
    run_cmd(32'h3000_0000, 0);
    wait_done(20);
    check("t3_beats", beats_seen, 0);
    check("t3_done", done_cnt, 1);

    // 70 DWs across a 4 KB boundary with random stalls.
    clear_obs();
    stall_en = 1'b1;
    queue_data(70, 32'hA000_0000, 32'h0102_0305);
    run_cmd(32'h0000_0FF0, 70);
    wait_done(3000);
    stall_en = 1'b0;
    check("t4_done", done_cnt, 1);
    check("t4_ntlp", obs_len.size(), 4);
    check("t4_split", (obs_len.size() == 4 && obs_addr.size() == 4) ?
          {obs_len[0][7:0], obs_len[1][7:0], obs_len[2][7:0], obs_len[3][7:0],
           obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]} : 128'h0,
          {8'd4, 8'd32, 8'd32, 8'd2, 32'h0FF0, 32'h1000, 32'h1080, 32'h1100});

    // Start with an empty FIFO, trickle data one DW per three cycles.
    clear_obs();
    push_on  = 1'b0;
    push_gap = 2;
    queue_data(8, 32'h5555_0001, 32'h0000_1001);
    run_cmd(32'h0000_4000, 8);
    push_on = 1'b1;
    wait_done(400);
    check("t5_done", done_cnt, 1);
    check("t5_beats", beats_seen, 6);
    push_gap = 0;

    // Reset in the middle of a 16-DW payload, then recover.
    clear_obs();
    queue_data(16, 32'h7700_0000, 32'h0000_0011);
    run_cmd(32'h5000_0000, 16);
    c = 0;
    while (beats_seen < 4 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("mid_wait", c < 200, 1'b1);
    sys_reset_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    pay_q.delete();
    src_q.delete();
    repeat (2) @(posedge clk);
    #1;
    sys_reset_n = 1'b1;
    clear_obs();
    queue_data(2, 32'hCAFE_0000, 32'h0000_0101);
    run_cmd(32'h6000_0008, 2);
    wait_done(200);
    check("t6_done", done_cnt, 1);
    check("t6_beats", beats_seen, 3);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
